fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/mips_pkg.sv | 14 +
 rtl/pc_check.sv | 24 ++
 rtl/fetch_ctrl.sv | 119 +++++++++++
 tb/tb_fetch_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: constants shared by the instruction-fetch front end.
//   ST_*              fetch controller state encoding
//   SYSCALL_INSN      instruction word that stops fetch
//   DEFAULT_RESET_PC  byte address fetched first after reset
package mips_pkg;

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_HALTED = 2'd1;
  localparam logic [1:0] ST_FAULT  = 2'd2;

  localparam logic [31:0] SYSCALL_INSN     = 32'h0000_000C;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

endpackage

// File: rtl/pc_check.sv
// pc_check: combinational legality check for a fetch byte address.
//   pc     in   32  byte address to check
//   legal  out  1   word aligned and inside the im window
//                   [RESET_PC, RESET_PC + 4*2**IM_AW - 4]
module pc_check
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          IM_AW    = 8
) (
  input  logic [31:0] pc,
  output logic        legal
);

  // Bounds are kept 33 bits wide so a window ending at the top of the
  // address space cannot wrap the upper limit.
  localparam logic [32:0] PC_LO = {1'b0, RESET_PC};
  localparam logic [32:0] PC_HI = PC_LO + (33'd4 << IM_AW) - 33'd4;

  assign legal = (pc[1:0] == 2'b00) &&
                 ({1'b0, pc} >= PC_LO) &&
                 ({1'b0, pc} <= PC_HI);

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch controller with a single IF/ID register.
//   clk             in   1      clock
//   reset           in   1      synchronous active-high reset
//   im_addr         out  IM_AW  word address to the instruction memory
//   im_data         in   32     combinational im read data
//   redirect_valid  in   1      branch/jump taken this cycle
//   redirect_pc     in   32     redirect target byte address
//   out_valid       out  1      IF/ID register holds an instruction
//   out_ready       in   1      decode accepts the instruction
//   out_instr       out  32     registered instruction word
//   out_pc          out  32     byte address of out_instr
//   halted          out  1      syscall fetched, fetch stopped
//   fault           out  1      illegal pc seen, fetch stopped
//   fetch_count     out  32     accepted handshakes (wraps)
//
// state      | meaning
// -----------+------------------------------------------------------
// ST_RUN     | fetching; capture, stall or redirect every cycle
// ST_HALTED  | syscall captured; drain it, then stay idle until reset
// ST_FAULT   | illegal pc seen; out_valid low until reset
module fetch_ctrl
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          IM_AW    = 8
) (
  input  logic             clk,
  input  logic             reset,
  output logic [IM_AW-1:0] im_addr,
  input  logic [31:0]      im_data,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [31:0]      out_pc,
  output logic             halted,
  output logic             fault,
  output logic [31:0]      fetch_count
);

  logic [1:0]  state;
  logic [31:0] pc;
  logic        pc_legal;
  logic        redir_legal;
  logic        capture;

  pc_check #(.RESET_PC(RESET_PC), .IM_AW(IM_AW)) u_pc_check (
    .pc    (pc),
    .legal (pc_legal)
  );

  pc_check #(.RESET_PC(RESET_PC), .IM_AW(IM_AW)) u_redir_check (
    .pc    (redirect_pc),
    .legal (redir_legal)
  );

  assign im_addr = pc[IM_AW+1:2];
  assign capture = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_RUN;
      pc          <= RESET_PC;
      out_valid   <= 1'b0;
      out_instr   <= 32'd0;
      out_pc      <= 32'd0;
      halted      <= 1'b0;
      fault       <= 1'b0;
      fetch_count <= 32'd0;
    end else begin
      // A handshake coinciding with a redirect still delivered its
      // instruction, so counting is independent of what happens below.
      if (out_valid && out_ready) begin
        fetch_count <= fetch_count + 32'd1;
      end

      case (state)
        ST_RUN: begin
          if (redirect_valid) begin
            out_valid <= 1'b0;
            if (redir_legal) begin
              pc <= redirect_pc;
            end else begin
              state <= ST_FAULT;
              fault <= 1'b1;
            end
          end else if (capture) begin
            if (!pc_legal) begin
              state     <= ST_FAULT;
              fault     <= 1'b1;
              out_valid <= 1'b0;
            end else begin
              out_instr <= im_data;
              out_pc    <= pc;
              out_valid <= 1'b1;
              // The syscall itself is delivered; pc stays on it.
              if (im_data == SYSCALL_INSN) begin
                state  <= ST_HALTED;
                halted <= 1'b1;
              end else begin
                pc <= pc + 32'd4;
              end
            end
          end
        end
        ST_HALTED: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: begin
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  im_addr;
  logic [31:0] im_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        halted;
  logic        fault;
  logic [31:0] fetch_count;

  logic [31:0] im_mem [256];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign im_data = im_mem[im_addr];

  fetch_ctrl #(.RESET_PC(32'h0000_3000), .IM_AW(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .im_addr        (im_addr),
    .im_data        (im_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .halted         (halted),
    .fault          (fault),
    .fetch_count    (fetch_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold reset for two edges, check the reset image, then release.
  task automatic do_reset();
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    out_ready      = 1'b1;
    step();
    step();
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_fault", {31'd0, fault}, 32'd0);
    check("rst_count", fetch_count, 32'd0);
    check("rst_pc", out_pc, 32'd0);
    check("rst_instr", out_instr, 32'd0);
    check("rst_im_addr", {24'd0, im_addr}, 32'd0);
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) im_mem[i] = 32'h2400_0000 | i;
    im_mem[0]   = 32'h2408_0001;
    im_mem[1]   = 32'h2409_0002;
    im_mem[255] = 32'h2400_00FF;

    // Straight-line fetch, then a three-cycle stall.
    do_reset();
    step();
    check("seq0_pc", out_pc, 32'h3000);
    check("seq0_instr", out_instr, 32'h2408_0001);
    check("seq0_valid", {31'd0, out_valid}, 32'd1);
    check("seq0_count", fetch_count, 32'd0);
    step();
    check("seq1_pc", out_pc, 32'h3004);
    check("seq1_instr", out_instr, 32'h2409_0002);
    check("seq1_count", fetch_count, 32'd1);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_pc", out_pc, 32'h3004);
      check("stall_instr", out_instr, 32'h2409_0002);
      check("stall_im_addr", {24'd0, im_addr}, 32'd2);
      check("stall_count", fetch_count, 32'd1);
      check("stall_valid", {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    step();
    check("unstall_pc", out_pc, 32'h3008);
    check("unstall_instr", out_instr, 32'h2400_0002);
    check("unstall_count", fetch_count, 32'd2);

    // Redirect while 0x3004 is presented and accepted.
    do_reset();
    step();
    step();
    check("redir_pre_pc", out_pc, 32'h3004);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h3010;
    step();
    redirect_valid = 1'b0;
    check("redir_flush_valid", {31'd0, out_valid}, 32'd0);
    check("redir_count", fetch_count, 32'd2);
    check("redir_im_addr", {24'd0, im_addr}, 32'd4);
    step();
    check("redir_tgt_pc", out_pc, 32'h3010);
    check("redir_tgt_instr", out_instr, 32'h2400_0004);
    check("redir_tgt_valid", {31'd0, out_valid}, 32'd1);
    check("redir_tgt_count", fetch_count, 32'd2);

    // Syscall at 0x3008 halts fetch; a redirect afterwards is ignored.
    im_mem[2] = 32'h0000_000C;
    do_reset();
    step();
    step();
    step();
    check("halt_pc", out_pc, 32'h3008);
    check("halt_instr", out_instr, 32'h0000_000C);
    check("halt_valid", {31'd0, out_valid}, 32'd1);
    check("halt_flag", {31'd0, halted}, 32'd1);
    check("halt_im_addr", {24'd0, im_addr}, 32'd2);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h3010;
    step();
    check("halt_drain_valid", {31'd0, out_valid}, 32'd0);
    check("halt_drain_count", fetch_count, 32'd3);
    step();
    redirect_valid = 1'b0;
    check("halt_idle_valid", {31'd0, out_valid}, 32'd0);
    check("halt_idle_im_addr", {24'd0, im_addr}, 32'd2);
    check("halt_idle_flag", {31'd0, halted}, 32'd1);
    check("halt_idle_pc", out_pc, 32'h3008);
    im_mem[2] = 32'h2400_0002;

    // Misaligned redirect target.
    do_reset();
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h3002;
    step();
    redirect_valid = 1'b0;
    check("mis_fault", {31'd0, fault}, 32'd1);
    check("mis_valid", {31'd0, out_valid}, 32'd0);
    check("mis_count", fetch_count, 32'd1);
    step();
    check("mis_hold_fault", {31'd0, fault}, 32'd1);
    check("mis_hold_valid", {31'd0, out_valid}, 32'd0);

    // Last legal word 0x33FC, then sequential fall-off into 0x3400.
    do_reset();
    step();
    check("restart_pc", out_pc, 32'h3000);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h33FC;
    step();
    redirect_valid = 1'b0;
    check("top_redir_fault", {31'd0, fault}, 32'd0);
    check("top_redir_valid", {31'd0, out_valid}, 32'd0);
    step();
    check("top_pc", out_pc, 32'h33FC);
    check("top_instr", out_instr, 32'h2400_00FF);
    check("top_valid", {31'd0, out_valid}, 32'd1);
    step();
    check("falloff_fault", {31'd0, fault}, 32'd1);
    check("falloff_valid", {31'd0, out_valid}, 32'd0);
    check("falloff_count", fetch_count, 32'd2);

    // Redirect just past the window, then recover through reset.
    do_reset();
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h3400;
    step();
    redirect_valid = 1'b0;
    check("oow_fault", {31'd0, fault}, 32'd1);
    check("oow_valid", {31'd0, out_valid}, 32'd0);
    do_reset();
    step();
    check("recover_pc", out_pc, 32'h3000);
    check("recover_instr", out_instr, 32'h2408_0001);
    check("recover_fault", {31'd0, fault}, 32'd0);

    // Reset in the middle of a stall discards everything.
    out_ready = 1'b0;
    step();
    step();
    check("midstall_pc", out_pc, 32'h3000);
    do_reset();
    step();
    check("midstall_restart_pc", out_pc, 32'h3000);
    check("midstall_restart_count", fetch_count, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
